fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range >= 2).
REQ-002 The block SHALL have parameter PARITY_EN, default 0, meaning 1 = append even-parity bit, 0 = none.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port enable  input  1  permits starting a new frame.
REQ-006 The block SHALL have port fifo_empty  input  1  sync FIFO empty flag.
REQ-007 The block SHALL have port fifo_data  input  8  FIFO head byte, valid whenever fifo_empty=0 (first-word-fall-through).
REQ-008 The block SHALL have port fifo_rd  output  1  pop strobe to FIFO; FIFO advances on the clock edge where fifo_rd=1.
REQ-009 The block SHALL have port tx  output  1  serial line, idle high, registered.
REQ-010 The block SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 The block SHALL have port tx_done  output  1  one-cycle pulse at end of frame.

Function
REQ-012 The block SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE, fifo_rd SHALL equal enable AND NOT fifo_empty (combinational), and never be 1 outside IDLE or while fifo_empty=1.
REQ-014 On the edge where fifo_rd=1 (cycle 0), fifo_data SHALL be captured into the shift register, the parity bit computed, and the state SHALL move to START.
REQ-015 Cycles are counted from cycle 0 with N = CLKS_PER_BIT: tx SHALL be 0 for cycles 1..N (start bit).
REQ-016 Data bit i (i = 0..7, LSB first) SHALL be driven on tx for cycles 1+(i+1)N .. (i+2)N.
REQ-017 If PARITY_EN=1, the even-parity bit (XOR of the 8 data bits) SHALL be driven for the N cycles after bit 7; if PARITY_EN=0, the PARITY state SHALL be skipped.
REQ-018 The stop bit (tx=1) SHALL last N cycles, and tx_done SHALL be 1 only in the last stop-bit cycle.
REQ-019 After the stop bit the state SHALL return to IDLE, with one IDLE cycle minimum between frames, giving a back-to-back frame period of 10N+1 cycles (11N+1 with parity).
REQ-020 busy SHALL be 1 in every non-IDLE cycle and 0 in IDLE.
REQ-021 The bit-time counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reset to 0 at each bit boundary, with no accumulated drift.
REQ-022 Deasserting enable mid-frame SHALL NOT abort the frame; only further pops are inhibited.
REQ-023 fifo_data and fifo_empty changes mid-frame SHALL NOT affect the byte being transmitted.

Reset
REQ-024 While reset=0 at a clock edge, the block SHALL set state=IDLE, tx=1, busy=0, tx_done=0, and clear the counters and shift register, taking effect on that edge.
REQ-025 fifo_rd SHALL be 0 during any cycle in which reset=0.
REQ-026 A reset mid-frame SHALL abandon the frame: tx=1 from the next cycle, with no tx_done pulse.
REQ-027 The first possible pop after reset SHALL be in the first cycle with reset=1.

Verification (N=16, PARITY_EN=0 unless stated)
REQ-028 Hold reset=0 for 3 cycles -> tx=1, busy=0, fifo_rd=0, tx_done=0 throughout.
REQ-029 Present a single byte 0xA5 with enable=1 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each for 16 cycles; tx_done in cycle 160; busy for cycles 1..160.
REQ-030 Present 3 queued bytes 0x00, 0xFF, 0x3C -> exactly 3 fifo_rd pulses spaced 161 cycles apart, with correct bit streams and no pop once fifo_empty=1.
REQ-031 Hold fifo_empty=1 with enable=1 for 500 cycles -> fifo_rd=0 and tx=1 constantly.
REQ-032 Drop enable in cycle 50 of a frame -> frame completes with tx_done; no pop until enable=1 again.
REQ-033 Apply reset=0 in cycle 70 (mid data) -> tx=1 next cycle with no tx_done; after release with fifo_empty=0, a fresh frame starts at the first cycle with reset=1.
REQ-034 With PARITY_EN=1, send byte 0x07 -> parity bit 1; frame period 177 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Serial transmitter fed from a first-word-fall-through FIFO. When idle and
//   enabled it pops the head byte and sends one frame on tx:
//     start (0), eight data bits LSB first, optional even parity, stop (1).
//   Every bit lasts CLKS_PER_BIT clocks. At least one idle cycle separates
//   frames, so the back-to-back period is 10N+1 clocks (11N+1 with parity).
//
// Parameters
//   CLKS_PER_BIT : clocks per serial bit (>= 2)
//   PARITY_EN    : 1 = append even-parity bit after bit 7, 0 = no parity
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low reset
//   enable     : permits starting a new frame (never aborts one in flight)
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO head byte, valid whenever fifo_empty = 0
//   fifo_rd    : pop strobe; the FIFO advances on the edge where it is 1
//   tx         : serial line, idle high, registered
//   busy       : high in every non-idle cycle
//   tx_done    : one-cycle pulse during the last stop-bit cycle
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE_LAST = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           tx_done_q, tx_done_d;
  logic           bit_end;

  // The pop is gated by reset so no byte is lost while reset is held.
  assign fifo_rd = (state_q == IDLE) && enable && !fifo_empty && reset;
  assign bit_end = (cnt_q == CNT_LAST);

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    tx_done_d = 1'b0;
    // Free-running bit timer; wraps to 0 on every bit boundary so bit
    // lengths never drift.
    cnt_d     = bit_end ? '0 : cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (fifo_rd) begin
          shift_d   = fifo_data;
          parity_d  = ^fifo_data;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            // tx_d takes bit 1 of the unshifted value: that is the next bit.
            tx_d      = shift_q[1];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // Registered pulse: raise it one cycle early so it lands on the
        // last stop-bit cycle.
        tx_done_d = (cnt_q == CNT_PRE_LAST);
        if (bit_end) begin
          busy_d    = 1'b0;
          tx_done_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx. Two instances share clk/reset: u_dut
//   (N=16, no parity) and u_par (N=16, even parity). Each has its own FIFO
//   model (a byte queue presenting first-word-fall-through data). Outputs are
//   sampled on the falling edge; inputs change 1 time unit after the rising
//   edge. Cycle 0 of a frame is the cycle in which fifo_rd is 1.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, fifo_empty, fifo_rd, tx, busy, tx_done;
  logic [7:0] fifo_data;
  logic       p_enable, p_fifo_empty, p_fifo_rd, p_tx, p_busy, p_tx_done;
  logic [7:0] p_fifo_data;

  logic [7:0] q_main[$];
  logic [7:0] q_par[$];

  // Sampled values for the current cycle.
  logic s_tx, s_busy, s_done, s_rd;
  logic sp_tx, sp_busy, sp_done, sp_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) u_par (
    .clk        (clk),
    .reset      (reset),
    .enable     (p_enable),
    .fifo_empty (p_fifo_empty),
    .fifo_data  (p_fifo_data),
    .fifo_rd    (p_fifo_rd),
    .tx         (p_tx),
    .busy       (p_busy),
    .tx_done    (p_tx_done)
  );

  task automatic refresh_fifos();
    fifo_empty   = (q_main.size() == 0);
    fifo_data    = fifo_empty ? 8'h00 : q_main[0];
    p_fifo_empty = (q_par.size() == 0);
    p_fifo_data  = p_fifo_empty ? 8'h00 : q_par[0];
  endtask

  // One clock cycle: sample mid-cycle, then let the FIFO models pop on the
  // edge that ends the cycle.
  task automatic tick();
    @(negedge clk);
    s_tx  = tx;    s_busy  = busy;    s_done  = tx_done;    s_rd  = fifo_rd;
    sp_tx = p_tx;  sp_busy = p_busy;  sp_done = p_tx_done;  sp_rd = p_fifo_rd;
    @(posedge clk);
    #1;
    if (s_rd && q_main.size() > 0) void'(q_main.pop_front());
    if (sp_rd && q_par.size() > 0) void'(q_par.pop_front());
    refresh_fifos();
  endtask

  // Expected line level k cycles after the pop cycle.
  function automatic logic exp_tx(input logic [7:0] b, input int k, input bit par);
    if (k <= N) return 1'b0;
    if (k <= 9 * N) return b[(k - N - 1) / N];
    if (par && k <= 10 * N) return ^b;
    return 1'b1;
  endfunction

  // Checks one full frame starting at cycle 0 (the pop cycle).
  // sel=0: u_dut, sel=1: u_par. drop_at>0 lowers enable before that cycle.
  task automatic check_frame(input bit sel, input logic [7:0] b,
                             input int drop_at, input string name);
    int len;
    logic t, bs, d, r;
    len = sel ? 11 * N : 10 * N;
    tick();
    r = sel ? sp_rd : s_rd;
    checks++;
    if (r !== 1'b1) begin
      errors++;
      $display("FAIL %s pop@0: fifo_rd=%b expected 1", name, r);
    end
    for (int k = 1; k <= len; k++) begin
      if (k == drop_at) enable = 1'b0;
      tick();
      t  = sel ? sp_tx   : s_tx;
      bs = sel ? sp_busy : s_busy;
      d  = sel ? sp_done : s_done;
      r  = sel ? sp_rd   : s_rd;
      checks += 4;
      if (t !== exp_tx(b, k, sel)) begin
        errors++;
        $display("FAIL %s tx@%0d: got %b expected %b", name, k, t, exp_tx(b, k, sel));
      end
      if (bs !== 1'b1) begin
        errors++;
        $display("FAIL %s busy@%0d: got %b expected 1", name, k, bs);
      end
      if (d !== (k == len)) begin
        errors++;
        $display("FAIL %s tx_done@%0d: got %b expected %b", name, k, d, (k == len));
      end
      if (r !== 1'b0) begin
        errors++;
        $display("FAIL %s fifo_rd@%0d: got %b expected 0", name, k, r);
      end
    end
  endtask

  // Idle cycles on u_dut: no pop, line high, not busy, no done pulse.
  task automatic check_idle(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      tick();
      checks += 4;
      if (s_rd !== 1'b0) begin
        errors++;
        $display("FAIL %s fifo_rd@%0d: got %b expected 0", name, k, s_rd);
      end
      if (s_tx !== 1'b1) begin
        errors++;
        $display("FAIL %s tx@%0d: got %b expected 1", name, k, s_tx);
      end
      if (s_busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy@%0d: got %b expected 0", name, k, s_busy);
      end
      if (s_done !== 1'b0) begin
        errors++;
        $display("FAIL %s tx_done@%0d: got %b expected 0", name, k, s_done);
      end
    end
  endtask

  // Reset held 3 cycles with a byte waiting and enable high: nothing moves.
  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    p_enable = 1'b0;
    q_main.push_back(8'hA5);
    refresh_fifos();
    check_idle(3, "reset");
    reset = 1'b1;
  endtask

  // 0xA5 pops in the first cycle with reset=1 and goes out as 0,1,0,1,0,0,1,0,1,1.
  task automatic test_single_byte();
    check_frame(1'b0, 8'hA5, 0, "single_a5");
    check_idle(3, "single_after");
  endtask

  // Three queued bytes: pops 161 cycles apart, then nothing once empty.
  task automatic test_back_to_back();
    q_main.push_back(8'h00);
    q_main.push_back(8'hFF);
    q_main.push_back(8'h3C);
    refresh_fifos();
    check_frame(1'b0, 8'h00, 0, "b2b_00");
    check_frame(1'b0, 8'hFF, 0, "b2b_ff");
    check_frame(1'b0, 8'h3C, 0, "b2b_3c");
    check_idle(5, "b2b_after");
  endtask

  task automatic test_empty_idle();
    enable = 1'b1;
    check_idle(500, "empty");
  endtask

  // enable drops at cycle 50: frame finishes, next byte waits for enable.
  task automatic test_enable_drop();
    q_main.push_back(8'h5A);
    q_main.push_back(8'hC3);
    refresh_fifos();
    check_frame(1'b0, 8'h5A, 50, "endrop_5a");
    check_idle(40, "endrop_hold");
    enable = 1'b1;
    check_frame(1'b0, 8'hC3, 0, "endrop_c3");
  endtask

  // Reset at cycle 70 (data bit 3): line high next cycle, no done, fresh pop
  // in the first cycle with reset=1.
  task automatic test_mid_reset();
    q_main.push_back(8'h96);
    q_main.push_back(8'h81);
    refresh_fifos();
    tick();
    checks++;
    if (s_rd !== 1'b1) begin
      errors++;
      $display("FAIL midrst pop@0: fifo_rd=%b expected 1", s_rd);
    end
    for (int k = 1; k < 70; k++) tick();
    reset = 1'b0;
    tick();  // cycle 70: still sending bit 3 of 0x96 (0), no pop allowed
    checks += 2;
    if (s_tx !== 1'b0) begin
      errors++;
      $display("FAIL midrst tx@70: got %b expected 0", s_tx);
    end
    if (s_rd !== 1'b0) begin
      errors++;
      $display("FAIL midrst fifo_rd@70: got %b expected 0", s_rd);
    end
    check_idle(1, "midrst_71");
    reset = 1'b1;
    check_frame(1'b0, 8'h81, 0, "midrst_81");
    check_idle(2, "midrst_after");
  endtask

  // Parity instance: 0x07 has three ones, so the parity bit is 1; two frames
  // back to back give a 177-cycle period.
  task automatic test_parity();
    enable = 1'b0;
    p_enable = 1'b1;
    q_par.push_back(8'h07);
    q_par.push_back(8'h07);
    refresh_fifos();
    check_frame(1'b1, 8'h07, 0, "par_07a");
    check_frame(1'b1, 8'h07, 0, "par_07b");
    tick();
    checks += 2;
    if (sp_rd !== 1'b0) begin
      errors++;
      $display("FAIL par_after fifo_rd: got %b expected 0", sp_rd);
    end
    if (sp_tx !== 1'b1) begin
      errors++;
      $display("FAIL par_after tx: got %b expected 1", sp_tx);
    end
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    p_enable = 1'b0;
    refresh_fifos();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty_idle();
    test_enable_drop();
    test_mid_reset();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
